// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller: MDU opcode
// encodings, MDU latencies, Tuse/Tnew field widths and the busy-counter
// width. No ports; imported by hazard_ctrl and mdu_busy_ctr.
package hazard_ctrl_pkg;

  localparam int REG_W    = 5;
  localparam int TUSE_W   = 2;
  localparam int TNEW_W   = 2;
  localparam int MDU_OP_W = 4;
  localparam int CNT_W    = 4;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  // Any encoding not listed here is a non-starting MDU op.
  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4
  } mdu_op_e;

  // Latency of an MDU op; zero means the op does not start the unit.
  function automatic logic [CNT_W-1:0] mdu_latency(input logic [MDU_OP_W-1:0] op);
    logic [CNT_W-1:0] lat;
    lat = '0;
    case (op)
      MDU_MULT, MDU_MULTU: lat = CNT_W'(MULT_CYC);
      MDU_DIV,  MDU_DIVU:  lat = CNT_W'(DIV_CYC);
      default:             lat = '0;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_busy_ctr.sv
// mdu_busy_ctr
// Tracks how many cycles the multiply/divide unit still needs.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous reset, active low
//   start    in   an MDU op issues this edge (already qualified by the flush)
//   op       in   MDU opcode of the issuing instruction
//   busy     out  registered, equals (busy_cnt != 0)
//   busy_cnt out  registered cycles remaining
module mdu_busy_ctr
  import hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  output logic                busy,
  output logic [CNT_W-1:0]    busy_cnt
);

  logic [CNT_W-1:0] lat;
  logic [CNT_W-1:0] cnt_next;

  // A valid start (re)loads the latency; otherwise count down and hold at 0.
  always_comb begin
    lat      = mdu_latency(op);
    cnt_next = busy_cnt;
    if (start && (lat != '0)) begin
      cnt_next = lat;
    end else if (busy_cnt != '0) begin
      cnt_next = busy_cnt - 1'b1;
    end
  end

  // busy is its own flop so it leaves the block registered, but it is
  // derived from the same next value so it always matches busy_cnt != 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      busy_cnt <= cnt_next;
      busy     <= (cnt_next != '0);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Stall generation for a 5-stage pipeline: register read-after-write
// hazards via Tuse/Tnew, MDU occupancy, and eret-after-EPC-write.
// Ports:
//   clk, reset                       clock, async active-low reset
//   RsD/RtD, UseRsD/UseRtD           D-stage source registers and use flags
//   TuseRsD/TuseRtD                  cycles until D needs each operand
//   RegDstE/M, RegWriteE/M, TnewE/M  producers in E and M
//   StartE, MDUOpE, MDUUseD          MDU issue in E and MDU use in D
//   EretD, EPCWriteE/M               eret in D, EPC writers in E/M
//   Req                              exception flush, overrides all stalls
//   StallPC, StallFD, BubbleDE       combinational stall controls
//   Busy, BusyCnt                    registered MDU occupancy
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_W-1:0]    RsD,
  input  logic [REG_W-1:0]    RtD,
  input  logic                UseRsD,
  input  logic                UseRtD,
  input  logic [TUSE_W-1:0]   TuseRsD,
  input  logic [TUSE_W-1:0]   TuseRtD,
  input  logic [REG_W-1:0]    RegDstE,
  input  logic [REG_W-1:0]    RegDstM,
  input  logic                RegWriteE,
  input  logic                RegWriteM,
  input  logic [TNEW_W-1:0]   TnewE,
  input  logic [TNEW_W-1:0]   TnewM,
  input  logic                StartE,
  input  logic [MDU_OP_W-1:0] MDUOpE,
  input  logic                MDUUseD,
  input  logic                EretD,
  input  logic                EPCWriteE,
  input  logic                EPCWriteM,
  input  logic                Req,
  output logic                StallPC,
  output logic                StallFD,
  output logic                BubbleDE,
  output logic                Busy,
  output logic [CNT_W-1:0]    BusyCnt
);

  logic rs_hazard;
  logic rt_hazard;
  logic mdu_hazard;
  logic eret_hazard;
  logic stall;
  logic stall_out;

  // A hazard exists when a later-stage producer writes our source register
  // but its result is not forwardable before we need it. $0 never stalls.
  always_comb begin
    rs_hazard = UseRsD && (RsD != '0) &&
                ((RegWriteE && (RegDstE == RsD) && (TuseRsD < TnewE)) ||
                 (RegWriteM && (RegDstM == RsD) && (TuseRsD < TnewM)));
    rt_hazard = UseRtD && (RtD != '0) &&
                ((RegWriteE && (RegDstE == RtD) && (TuseRtD < TnewE)) ||
                 (RegWriteM && (RegDstM == RtD) && (TuseRtD < TnewM)));
    mdu_hazard  = MDUUseD && (StartE || Busy);
    eret_hazard = EretD && (EPCWriteE || EPCWriteM);
    stall       = rs_hazard || rt_hazard || mdu_hazard || eret_hazard;
    // A flush wins over every hazard, and nothing stalls while in reset.
    stall_out   = stall && !Req && reset;
  end

  assign StallPC  = stall_out;
  assign StallFD  = stall_out;
  assign BubbleDE = stall_out;

  // A start that coincides with a flush belongs to a squashed instruction.
  mdu_busy_ctr u_mdu_busy_ctr (
    .clk      (clk),
    .reset    (reset),
    .start    (StartE && !Req),
    .op       (MDUOpE),
    .busy     (Busy),
    .busy_cnt (BusyCnt)
  );

endmodule
